cp0_exception: RTL and testbench

Coprocessor-0 register file and precise-exception responder for the five-stage MIPS core. It consumes the trap and invalid-instruction flags raised in decode, carried down the pipeline to the memory stage, plus overflow, address-error and hardware-interrupt sources. It prioritises them, updates Status/Cause/EPC/BadVAddr, and drives the pipeline flush and redirect PC. It also serves `mfc0`/`mtc0` traffic and runs the Count/Compare timer.

---
 rtl/cp0_exception.sv | 152 +++++++++++++++
 tb/tb_cp0_exception.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception.sv
// Coprocessor-0 register file and precise-exception responder for the five-stage MIPS core.
// Optional feature: define CP0_TIMER_INT_EN to route Count==Compare into Cause.TI / IP[7].
module cp0_exception #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        invalidM,
  input  logic        syscallM,
  input  logic        breakM,
  input  logic        eretM,
  input  logic        overflowM,
  input  logic        adel_fetchM,
  input  logic        adel_loadM,
  input  logic        ades_storeM,
  input  logic [31:0] pcM,
  input  logic [31:0] bad_addrM,
  input  logic        in_delayslotM,
  input  logic [5:0]  hw_int,
  input  logic        cp0weM,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic        flush,
  output logic [31:0] newpc,
  output logic [4:0]  excode,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] status, epc, badvaddr, count, compare;
  logic [4:0]  ip_hw;
  logic        ip7;
  logic [1:0]  ip_sw;
  logic        bd, ti, toggle;
  logic [4:0]  exc_code_r;
  logic [7:0]  ip;

  logic        int_pending, exc_hit, take_exc, take_eret, mtc0_commit;
  logic        bad_from_pc, bad_from_data;
  logic [4:0]  code;

  assign ip = {ip7, ip_hw, ip_sw};
  assign int_pending = status[0] & ~status[1] & (|(ip & status[15:8]));

  // Fixed priority; the first asserted source wins and selects BadVAddr source.
  always_comb begin
    exc_hit       = 1'b1;
    code          = 5'h00;
    bad_from_pc   = 1'b0;
    bad_from_data = 1'b0;
    if (int_pending)      code = 5'h00;
    else if (adel_fetchM) begin code = 5'h04; bad_from_pc = 1'b1; end
    else if (invalidM)    code = 5'h0A;
    else if (syscallM)    code = 5'h08;
    else if (breakM)      code = 5'h09;
    else if (overflowM)   code = 5'h0C;
    else if (adel_loadM)  begin code = 5'h04; bad_from_data = 1'b1; end
    else if (ades_storeM) begin code = 5'h05; bad_from_data = 1'b1; end
    else                  exc_hit = 1'b0;
  end

  assign take_exc    = exc_hit & ~stall;
  assign take_eret   = eretM & ~exc_hit & ~stall;
  assign flush       = take_exc | take_eret;
  assign newpc       = take_eret ? epc : EXC_VECTOR;
  assign excode      = take_exc ? code : 5'h00;
  // An mtc0 in the same cycle as a redirect belongs to a squashed instruction.
  assign mtc0_commit = cp0weM & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= STATUS_RST;
      epc        <= 32'h0;
      badvaddr   <= 32'h0;
      count      <= 32'h0;
      compare    <= 32'h0;
      ip_hw      <= 5'h0;
      ip_sw      <= 2'h0;
      bd         <= 1'b0;
      exc_code_r <= 5'h0;
      toggle     <= 1'b0;
    end else begin
      toggle <= ~toggle;
      ip_hw  <= hw_int[4:0];
      if (mtc0_commit && waddr == 5'd9) count <= wdata;
      else if (toggle)                  count <= count + 32'd1;
      if (mtc0_commit && waddr == 5'd11) compare <= wdata;

      if (take_exc) begin
        status[1]  <= 1'b1;
        exc_code_r <= code;
        if (!status[1]) begin
          bd  <= in_delayslotM;
          epc <= in_delayslotM ? (pcM - 32'd4) : pcM;
        end
        if (bad_from_pc)        badvaddr <= pcM;
        else if (bad_from_data) badvaddr <= bad_addrM;
      end else if (take_eret) begin
        status[1] <= 1'b0;
      end else if (mtc0_commit) begin
        case (waddr)
          5'd12:   status <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
          5'd13:   ip_sw  <= wdata[9:8];
          5'd14:   epc    <= wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_INT_EN
  // A Compare write acknowledges the timer even if the match condition still holds.
  always_ff @(posedge clk) begin
    if (rst)                                 ti <= 1'b0;
    else if (mtc0_commit && waddr == 5'd11)  ti <= 1'b0;
    else if (count == compare)               ti <= 1'b1;
  end
  assign ip7 = ti;
`else
  assign ti = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) ip7 <= 1'b0;
    else     ip7 <= hw_int[5];
  end
`endif

  assign timer_int = ti;
  assign status_o  = status;
  assign epc_o     = epc;
  assign cause_o   = {bd, ti, 14'h0, ip, 1'b0, exc_code_r, 2'b00};

  always_comb begin
    case (raddr)
      5'd8:    rdata = badvaddr;
      5'd9:    rdata = count;
      5'd11:   rdata = compare;
      5'd12:   rdata = status;
      5'd13:   rdata = cause_o;
      5'd14:   rdata = epc;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception.sv
// Directed-vector bench for cp0_exception: exceptions, eret, mtc0/mfc0, interrupts, Count/Compare.
module tb_cp0_exception;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst, stall, invalidM, syscallM, breakM, eretM, overflowM;
  logic        adel_fetchM, adel_loadM, ades_storeM, in_delayslotM, cp0weM;
  logic [31:0] pcM, bad_addrM, wdata, rdata, newpc, status_o, cause_o, epc_o;
  logic [5:0]  hw_int;
  logic [4:0]  waddr, raddr, excode;
  logic        flush, timer_int;

  int errors = 0;
  int checks = 0;

  cp0_exception dut (
    .clk(clk), .rst(rst), .stall(stall), .invalidM(invalidM), .syscallM(syscallM),
    .breakM(breakM), .eretM(eretM), .overflowM(overflowM), .adel_fetchM(adel_fetchM),
    .adel_loadM(adel_loadM), .ades_storeM(ades_storeM), .pcM(pcM), .bad_addrM(bad_addrM),
    .in_delayslotM(in_delayslotM), .hw_int(hw_int), .cp0weM(cp0weM), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .flush(flush), .newpc(newpc),
    .excode(excode), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int(timer_int)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; invalidM = 0; syscallM = 0; breakM = 0; eretM = 0; overflowM = 0;
    adel_fetchM = 0; adel_loadM = 0; ades_storeM = 0; in_delayslotM = 0; cp0weM = 0;
    pcM = 0; bad_addrM = 0; waddr = 0; wdata = 0;
  endtask

  task automatic do_eret();
    idle(); eretM = 1; tick(); idle(); #1;
  endtask

  task automatic test_reset();
    idle(); hw_int = 0; raddr = 0; rst = 1;
    tick(); rst = 0; #1;
    raddr = 12; #1; checks++;
    if (rdata !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h required %h", rdata, 32'h0040_0000); end
    raddr = 13; #1; checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h required 0", rdata); end
    raddr = 14; #1; checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h required 0", rdata); end
    raddr = 8; #1; checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_badvaddr: got %h required 0", rdata); end
    checks++;
    if (flush !== 1'b0 || newpc !== VEC || excode !== 5'h0 || timer_int !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got flush=%b newpc=%h excode=%h ti=%b required 0 %h 0 0", flush, newpc, excode, timer_int, VEC);
    end
  endtask

  task automatic test_syscall();
    idle(); syscallM = 1; pcM = 32'hBFC0_0100; #1; checks++;
    if (flush !== 1'b1 || newpc !== VEC || excode !== 5'h08) begin
      errors++; $display("FAIL syscall_redirect: got flush=%b newpc=%h excode=%h required 1 %h 08", flush, newpc, excode, VEC);
    end
    tick(); idle(); #1; checks++;
    if (epc_o !== 32'hBFC0_0100 || cause_o[6:2] !== 5'h08 || status_o[1] !== 1'b1 || cause_o[31] !== 1'b0) begin
      errors++; $display("FAIL syscall_regs: got epc=%h code=%h exl=%b bd=%b required bfc00100 08 1 0", epc_o, cause_o[6:2], status_o[1], cause_o[31]);
    end
  endtask

  task automatic test_eret_stall();
    idle(); stall = 1; eretM = 1; #1; checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL eret_stall_flush: got %b required 0", flush); end
    tick(); checks++;
    if (status_o[1] !== 1'b1) begin errors++; $display("FAIL eret_stall_exl: got %b required 1", status_o[1]); end
    stall = 0; #1; checks++;
    if (flush !== 1'b1 || newpc !== 32'hBFC0_0100) begin
      errors++; $display("FAIL eret_newpc: got flush=%b newpc=%h required 1 bfc00100", flush, newpc);
    end
    tick(); idle(); #1; checks++;
    if (status_o[1] !== 1'b0) begin errors++; $display("FAIL eret_exl: got %b required 0", status_o[1]); end
  endtask

  task automatic test_priority();
    idle(); invalidM = 1; overflowM = 1; in_delayslotM = 1; pcM = 32'h80; #1; checks++;
    if (flush !== 1'b1 || excode !== 5'h0A) begin
      errors++; $display("FAIL prio_invalid: got flush=%b excode=%h required 1 0a", flush, excode);
    end
    tick(); idle(); #1; checks++;
    if (epc_o !== 32'h7C || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'h0A) begin
      errors++; $display("FAIL prio_regs: got epc=%h bd=%b code=%h required 7c 1 0a", epc_o, cause_o[31], cause_o[6:2]);
    end
  endtask

  task automatic test_nested();
    idle(); breakM = 1; pcM = 32'h200; #1; checks++;
    if (excode !== 5'h09) begin errors++; $display("FAIL nested_code: got %h required 09", excode); end
    tick(); idle(); #1; checks++;
    if (epc_o !== 32'h7C || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'h09 || status_o[1] !== 1'b1) begin
      errors++; $display("FAIL nested_regs: got epc=%h bd=%b code=%h exl=%b required 7c 1 09 1", epc_o, cause_o[31], cause_o[6:2], status_o[1]);
    end
    idle(); eretM = 1; #1; checks++;
    if (newpc !== 32'h7C) begin errors++; $display("FAIL eret_epc: got %h required 7c", newpc); end
    tick(); idle(); #1;
  endtask

  task automatic test_stall_exc();
    idle(); stall = 1; syscallM = 1; pcM = 32'h400; #1; checks++;
    if (flush !== 1'b0 || excode !== 5'h0) begin
      errors++; $display("FAIL stall_exc: got flush=%b excode=%h required 0 0", flush, excode);
    end
    tick(); idle(); #1; checks++;
    if (cause_o[6:2] !== 5'h09 || status_o[1] !== 1'b0 || epc_o !== 32'h7C) begin
      errors++; $display("FAIL stall_regs: got code=%h exl=%b epc=%h required 09 0 7c", cause_o[6:2], status_o[1], epc_o);
    end
  endtask

  task automatic test_mtc0();
    idle(); cp0weM = 1; waddr = 12; wdata = 32'hFFFF_FFFF; raddr = 12; #1; checks++;
    if (rdata !== 32'h0040_0000) begin errors++; $display("FAIL mfc0_no_bypass: got %h required 00400000", rdata); end
    tick(); checks++;
    if (status_o !== 32'h0040_FF03) begin errors++; $display("FAIL mtc0_status_mask: got %h required 0040ff03", status_o); end
    wdata = 32'h0000_0401; tick(); checks++;
    if (status_o !== 32'h0040_0401) begin errors++; $display("FAIL mtc0_status: got %h required 00400401", status_o); end
    waddr = 13; wdata = 32'hFFFF_FFFF; tick(); checks++;
    if (cause_o[9:8] !== 2'b11 || cause_o[6:2] !== 5'h09 || cause_o[31] !== 1'b1) begin
      errors++; $display("FAIL mtc0_cause: got %h required ip_sw=3 code=09 bd=1", cause_o);
    end
    wdata = 32'h0; tick();
    waddr = 8; wdata = 32'h1234; tick(); idle(); raddr = 8; #1; checks++;
    if (rdata !== 32'h0 || cause_o[9:8] !== 2'b00) begin
      errors++; $display("FAIL mtc0_badvaddr_ro: got bad=%h ip_sw=%b required 0 0", rdata, cause_o[9:8]);
    end
  endtask

  task automatic test_interrupt();
    idle(); hw_int = 6'b000001; #1; checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL int_presample: got %b required 0", flush); end
    tick(); checks++;
    if (flush !== 1'b1 || excode !== 5'h00 || newpc !== VEC) begin
      errors++; $display("FAIL int_taken: got flush=%b excode=%h newpc=%h required 1 00 %h", flush, excode, newpc, VEC);
    end
    cp0weM = 1; waddr = 14; wdata = 32'hDEAD_BEEF; pcM = 32'h300; #1;
    tick(); idle(); hw_int = 0; #1; checks++;
    if (epc_o !== 32'h300 || cause_o[6:2] !== 5'h00 || status_o[1] !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL int_regs: got epc=%h code=%h exl=%b flush=%b required 300 00 1 0", epc_o, cause_o[6:2], status_o[1], flush);
    end
  endtask

  task automatic test_addr_errors();
    idle(); eretM = 1; cp0weM = 1; waddr = 14; wdata = 32'h55; #1; checks++;
    if (flush !== 1'b1 || newpc !== 32'h300) begin
      errors++; $display("FAIL eret_mtc0_redirect: got flush=%b newpc=%h required 1 300", flush, newpc);
    end
    tick(); idle(); #1; checks++;
    if (epc_o !== 32'h300 || status_o[1] !== 1'b0) begin
      errors++; $display("FAIL eret_mtc0_discard: got epc=%h exl=%b required 300 0", epc_o, status_o[1]);
    end
    adel_fetchM = 1; adel_loadM = 1; pcM = 32'h401; bad_addrM = 32'h9999; #1; checks++;
    if (excode !== 5'h04) begin errors++; $display("FAIL adel_fetch_code: got %h required 04", excode); end
    tick(); idle(); raddr = 8; #1; checks++;
    if (rdata !== 32'h401 || epc_o !== 32'h401) begin
      errors++; $display("FAIL adel_fetch_regs: got bad=%h epc=%h required 401 401", rdata, epc_o);
    end
    do_eret();
    adel_loadM = 1; pcM = 32'h500; bad_addrM = 32'h1003; #1; checks++;
    if (excode !== 5'h04) begin errors++; $display("FAIL adel_load_code: got %h required 04", excode); end
    tick(); idle(); #1; checks++;
    if (rdata !== 32'h1003) begin errors++; $display("FAIL adel_load_bad: got %h required 1003", rdata); end
    do_eret();
    ades_storeM = 1; overflowM = 1; pcM = 32'h600; bad_addrM = 32'h2000; #1; checks++;
    if (excode !== 5'h0C) begin errors++; $display("FAIL ovf_over_store: got %h required 0c", excode); end
    tick(); idle(); #1; checks++;
    if (rdata !== 32'h1003) begin errors++; $display("FAIL ovf_bad_keep: got %h required 1003", rdata); end
    do_eret();
    ades_storeM = 1; pcM = 32'h700; bad_addrM = 32'h2002; #1; checks++;
    if (excode !== 5'h05) begin errors++; $display("FAIL ades_code: got %h required 05", excode); end
    tick(); idle(); #1; checks++;
    if (rdata !== 32'h2002 || cause_o[6:2] !== 5'h05) begin
      errors++; $display("FAIL ades_regs: got bad=%h code=%h required 2002 05", rdata, cause_o[6:2]);
    end
    do_eret();
  endtask

  task automatic test_count();
    idle(); cp0weM = 1; waddr = 9; wdata = 32'hFFFF_FFFE; tick(); idle(); raddr = 9; #1; checks++;
    if (rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL count_write: got %h required fffffffe", rdata); end
    stall = 1; tick(); tick(); checks++;
    if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_half_rate: got %h required ffffffff", rdata); end
    tick(); tick(); stall = 0; #1; checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h required 0", rdata); end
  endtask

  task automatic test_timer();
    int n;
    bit seen;
    idle(); cp0weM = 1; waddr = 11; wdata = 32'd10; tick();
    waddr = 9; wdata = 32'd0; tick(); idle(); #1;
    checks++;
    if (timer_int !== 1'b0) begin errors++; $display("FAIL timer_clear_start: got %b required 0", timer_int); end
`ifdef CP0_TIMER_INT_EN
    seen = 0; n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (timer_int === 1'b1) begin seen = 1; n = i; end
    end
    checks++;
    if (!seen || n < 20 || n > 21) begin
      errors++; $display("FAIL timer_rise: got cycle %0d (seen=%0d) required 20..21", n, seen);
    end
    checks++;
    if (cause_o[30] !== 1'b1 || cause_o[15] !== 1'b1) begin
      errors++; $display("FAIL timer_cause: got ti=%b ip7=%b required 1 1", cause_o[30], cause_o[15]);
    end
    cp0weM = 1; waddr = 11; wdata = 32'h100; tick(); idle(); #1; checks++;
    if (timer_int !== 1'b0) begin errors++; $display("FAIL timer_ack: got %b required 0", timer_int); end
`else
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (timer_int !== 1'b0 || cause_o[30] !== 1'b0) begin
      errors++; $display("FAIL timer_disabled: got ti=%b cause_ti=%b required 0 0", timer_int, cause_o[30]);
    end
    hw_int = 6'b100000; tick(); checks++;
    if (cause_o[15] !== 1'b1) begin errors++; $display("FAIL ip7_hw: got %b required 1", cause_o[15]); end
    hw_int = 0; tick();
`endif
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_eret_stall();
    test_priority();
    test_nested();
    test_stall_exc();
    test_mtc0();
    test_interrupt();
    test_addr_errors();
    test_count();
    test_timer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
